// File: rtl/add_accumulator.sv
// Streaming accumulator: each accepted operand is added through an N-stage ripple-carry
// datapath, and the carry-outs are counted in CW extra high-order bits.

module fulladd (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module add_accumulator #(
    parameter int N  = 4,
    parameter int CW = 4
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N+CW-1:0]   out_sum,
    output logic              out_ovf,
    output logic [7:0]        out_terms
);
    // state | meaning
    // IDLE  | waiting for the first operand of a new sum
    // ACCUM | adding further operands until one is marked last
    // DONE  | total presented downstream, waiting for out_ready
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [N+CW-1:0]   r_acc;
    logic              r_ovf;
    logic [7:0]        r_terms;
    logic              r_armed;

    logic [N:0]        w_carry;
    logic [N-1:0]      w_sum_lo;
    logic [CW-1:0]     w_upper_inc;
    logic              w_wrap;
    logic              w_accept;

    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_ripple
        fulladd u_fa (
            .i_a    (r_acc[i]),
            .i_b    (in_data[i]),
            .i_cin  (w_carry[i]),
            .o_s    (w_sum_lo[i]),
            .o_cout (w_carry[i+1])
        );
    end

    assign w_upper_inc = r_acc[N+CW-1:N] + CW'(w_carry[N]);
    assign w_wrap      = w_carry[N] & (&r_acc[N+CW-1:N]);

    // r_armed keeps in_ready low for the cycle right after a reset edge
    assign in_ready  = r_armed && (r_state != S_DONE);
    assign out_valid = (r_state == S_DONE);
    assign w_accept  = in_valid && in_ready;

    assign out_sum   = r_acc;
    assign out_ovf   = r_ovf;
    assign out_terms = r_terms;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = in_last ? S_DONE : S_ACCUM;
            end
            S_ACCUM: begin
                if (w_accept && in_last) w_next = S_DONE;
            end
            S_DONE: begin
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_terms <= 8'd0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_next;
            r_armed <= 1'b1;
            if (w_accept) begin
                if (r_state == S_IDLE) begin
                    r_acc   <= {{CW{1'b0}}, in_data};
                    r_ovf   <= 1'b0;
                    r_terms <= 8'd1;
                end else begin
                    r_acc   <= {w_upper_inc, w_sum_lo};
                    r_ovf   <= r_ovf | w_wrap;
                    r_terms <= r_terms + {7'd0, (r_terms != 8'd255)};
                end
            end
        end
    end
endmodule

// File: tb/tb_add_accumulator.sv
// Directed bench for add_accumulator: each scenario task drives beats and checks the
// presented total against hand-computed values.

module tb_add_accumulator;
    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = 4'd0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_sum;
    logic       out_ovf;
    logic [7:0] out_terms;

    int checks = 0;
    int failures = 0;

    add_accumulator #(.N(4), .CW(4)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_terms (out_terms)
    );

    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_beat(input logic [3:0] d, input logic l);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge Clock);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end
        @(posedge Clock);
        @(negedge Clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge Clock);
            n++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        checks++;
        if ({in_ready, out_valid, out_sum, out_ovf, out_terms} !== 19'd0) begin
            failures++;
            $display("FAIL reset_state: rdy=%0b vld=%0b sum=%0d ovf=%0b terms=%0d, required all 0",
                     in_ready, out_valid, out_sum, out_ovf, out_terms);
        end
        Resetn = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: rdy=%0b vld=%0b, required rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        send_beat(4'd3, 1'b0);
        send_beat(4'd5, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL t1_early_valid: out_valid=%0b mid-sum, required 0", out_valid);
        end
        send_beat(4'd7, 1'b1);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL t1_latency: out_valid=%0b one cycle after last beat, required 1", out_valid);
        end
        checks++;
        if ({out_sum, out_ovf, out_terms} !== {8'd15, 1'b0, 8'd3}) begin
            failures++;
            $display("FAIL t1_result: sum=%0d ovf=%0b terms=%0d, required 15 0 3", out_sum, out_ovf, out_terms);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL t1_return_idle: vld=%0b rdy=%0b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_carry();
        for (int i = 0; i < 4; i++) send_beat(4'd15, (i == 3));
        wait_valid();
        checks++;
        if ({out_valid, out_sum, out_ovf, out_terms} !== {1'b1, 8'h3C, 1'b0, 8'd4}) begin
            failures++;
            $display("FAIL t2_carry: vld=%0b sum=%0h ovf=%0b terms=%0d, required 1 3c 0 4",
                     out_valid, out_sum, out_ovf, out_terms);
        end
        consume();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 18; i++) send_beat(4'd15, (i == 17));
        wait_valid();
        checks++;
        if ({out_valid, out_sum, out_ovf, out_terms} !== {1'b1, 8'd14, 1'b1, 8'd18}) begin
            failures++;
            $display("FAIL t3_overflow: vld=%0b sum=%0d ovf=%0b terms=%0d, required 1 14 1 18",
                     out_valid, out_sum, out_ovf, out_terms);
        end
        consume();
    endtask

    task automatic test_ovf_clear();
        send_beat(4'd1, 1'b0);
        send_beat(4'd2, 1'b1);
        wait_valid();
        checks++;
        if ({out_valid, out_sum, out_ovf, out_terms} !== {1'b1, 8'd3, 1'b0, 8'd2}) begin
            failures++;
            $display("FAIL ovf_clear: vld=%0b sum=%0d ovf=%0b terms=%0d, required 1 3 0 2",
                     out_valid, out_sum, out_ovf, out_terms);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        send_beat(4'd9, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 8'd9 || out_terms !== 8'd1) bad++;
            @(negedge Clock);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL t4_hold: %0d unstable cycles (last vld=%0b rdy=%0b sum=%0d), required 0",
                     bad, out_valid, in_ready, out_sum);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL t4_release: vld=%0b rdy=%0b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_sum();
        send_beat(4'd4, 1'b0);
        send_beat(4'd4, 1'b0);
        Resetn = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 8'd0) begin
            failures++;
            $display("FAIL t5_reset_clear: vld=%0b sum=%0d, required 0 0", out_valid, out_sum);
        end
        send_beat(4'd2, 1'b1);
        wait_valid();
        checks++;
        if ({out_valid, out_sum, out_ovf, out_terms} !== {1'b1, 8'd2, 1'b0, 8'd1}) begin
            failures++;
            $display("FAIL t5_discard: vld=%0b sum=%0d ovf=%0b terms=%0d, required 1 2 0 1",
                     out_valid, out_sum, out_ovf, out_terms);
        end
        consume();
    endtask

    task automatic test_saturate();
        int stall_bad;
        stall_bad = 0;
        for (int i = 0; i < 300; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge Clock);
                if (i > 0 && (out_valid !== 1'b0 || in_ready !== 1'b1)) stall_bad++;
            end
            send_beat(4'd1, (i == 299));
        end
        checks++;
        if (stall_bad != 0) begin
            failures++;
            $display("FAIL t6_stall: %0d bad gap cycles, required 0", stall_bad);
        end
        wait_valid();
        checks++;
        if ({out_valid, out_sum, out_ovf, out_terms} !== {1'b1, 8'd44, 1'b1, 8'd255}) begin
            failures++;
            $display("FAIL t6_saturate: vld=%0b sum=%0d ovf=%0b terms=%0d, required 1 44 1 255",
                     out_valid, out_sum, out_ovf, out_terms);
        end
        consume();
    endtask

    initial begin
        @(negedge Clock);
        test_reset();
        test_basic();
        test_carry();
        test_overflow();
        test_ovf_clear();
        test_backpressure();
        test_reset_mid_sum();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
